// File: rtl/braid_inlet_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : braid_inlet_meter                                            |
// | Description : Sequential dose metering for the braid mixer inlets: one     |
// |               valve at a time, settle interval, then pumped dose.          |
// |               Optional flush phase enabled by BRAID_METER_FLUSH_EN.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module braid_inlet_meter #(
  parameter int N_IN       = 4,
  parameter int DOSE_W     = 8,
  parameter int SETTLE_CYC = 4,
  parameter int FLUSH_CYC  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [N_IN*DOSE_W-1:0]   cfg_dose,
  input  logic                     abort,
  output logic [N_IN-1:0]          valve_open,
  output logic                     pump_en,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [DOSE_W+1:0]        pumped_total
);

  localparam int c_k_w     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int c_pt_w    = DOSE_W + 2;
  localparam int c_set_w   = $clog2(SETTLE_CYC + 1);
  localparam int c_fl_w    = $clog2(FLUSH_CYC + 1);
  localparam int c_cnt_w_a = (DOSE_W > c_set_w) ? DOSE_W : c_set_w;
  localparam int c_cnt_w   = (c_cnt_w_a > c_fl_w) ? c_cnt_w_a : c_fl_w;

  localparam logic [c_cnt_w-1:0] c_settle_ld = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_pt_w-1:0]  c_pt_one    = c_pt_w'(1);
  localparam logic [N_IN-1:0]    c_valve_one = N_IN'(1);
  localparam logic [DOSE_W-1:0]  c_dose_one  = DOSE_W'(1);
`ifdef BRAID_METER_FLUSH_EN
  localparam logic [c_cnt_w-1:0] c_flush_ld  = c_cnt_w'(FLUSH_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_DISPENSE = 3'd2,
`ifdef BRAID_METER_FLUSH_EN
    S_FLUSH    = 3'd4,
`endif
    S_DONE     = 3'd3
  } state_t;

  state_t                    r_state;
  logic [N_IN*DOSE_W-1:0]    r_dose;
  logic [c_k_w-1:0]          r_k;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [N_IN-1:0]           r_valve;
  logic                      r_pump;
  logic                      r_done;
  logic                      r_aborted;
  logic [c_pt_w-1:0]         r_pt;

  logic                      w_first_found;
  logic [c_k_w-1:0]          w_first_idx;
  logic                      w_next_found;
  logic [c_k_w-1:0]          w_next_idx;
  logic [DOSE_W-1:0]         w_dose_k;
  logic [DOSE_W-1:0]         w_dose_m1;
  logic [c_pt_w-1:0]         w_pt_inc;

  // Downward scan so the last hit is the lowest qualifying index.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = '0;
    w_next_found  = 1'b0;
    w_next_idx    = '0;
    w_dose_k      = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (cfg_dose[i*DOSE_W +: DOSE_W] != '0) begin
        w_first_found = 1'b1;
        w_first_idx   = c_k_w'(i);
      end
      if ((r_dose[i*DOSE_W +: DOSE_W] != '0) && (i > int'(r_k))) begin
        w_next_found = 1'b1;
        w_next_idx   = c_k_w'(i);
      end
      if (c_k_w'(i) == r_k) begin
        w_dose_k = r_dose[i*DOSE_W +: DOSE_W];
      end
    end
  end

  assign w_dose_m1 = w_dose_k - c_dose_one;
  // Saturate rather than wrap if the inlet count exceeds the sizing case.
  assign w_pt_inc  = (r_pt == '1) ? r_pt : (r_pt + c_pt_one);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dose    <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_valve   <= '0;
      r_pump    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_pt      <= '0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        r_state   <= S_IDLE;
        r_valve   <= '0;
        r_pump    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cfg_valid) begin
              r_dose <= cfg_dose;
              r_pt   <= '0;
              r_k    <= w_first_idx;
              if (w_first_found) begin
                r_state <= S_SETTLE;
                r_valve <= c_valve_one << w_first_idx;
                r_pump  <= 1'b0;
                r_cnt   <= c_settle_ld;
              end else begin
`ifdef BRAID_METER_FLUSH_EN
                r_state <= S_FLUSH;
                r_valve <= '1;
                r_pump  <= 1'b1;
                r_cnt   <= c_flush_ld;
`else
                r_state <= S_DONE;
                r_valve <= '0;
                r_pump  <= 1'b0;
                r_done  <= 1'b1;
`endif
              end
            end
          end
          S_SETTLE: begin
            if (r_cnt == '0) begin
              r_state <= S_DISPENSE;
              r_pump  <= 1'b1;
              r_cnt   <= c_cnt_w'(w_dose_m1);
              r_pt    <= w_pt_inc;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          S_DISPENSE: begin
            if (r_cnt == '0) begin
              if (w_next_found) begin
                r_state <= S_SETTLE;
                r_k     <= w_next_idx;
                r_valve <= c_valve_one << w_next_idx;
                r_pump  <= 1'b0;
                r_cnt   <= c_settle_ld;
              end else begin
`ifdef BRAID_METER_FLUSH_EN
                r_state <= S_FLUSH;
                r_valve <= '1;
                r_pump  <= 1'b1;
                r_cnt   <= c_flush_ld;
`else
                r_state <= S_DONE;
                r_valve <= '0;
                r_pump  <= 1'b0;
                r_done  <= 1'b1;
`endif
              end
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
              r_pt  <= w_pt_inc;
            end
          end
`ifdef BRAID_METER_FLUSH_EN
          S_FLUSH: begin
            if (r_cnt == '0) begin
              r_state <= S_DONE;
              r_valve <= '0;
              r_pump  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
`endif
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_valve <= '0;
            r_pump  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign valve_open   = r_valve;
  assign pump_en      = r_pump;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign pumped_total = r_pt;

endmodule
`default_nettype wire

// File: tb/tb_braid_inlet_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_braid_inlet_meter                                         |
// | Description : Randomized self-checking bench against a per-cycle schedule  |
// |               model; follows BRAID_METER_FLUSH_EN when it is defined.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_braid_inlet_meter;

  localparam int N_IN       = 4;
  localparam int DOSE_W     = 8;
  localparam int SETTLE_CYC = 2;
  localparam int FLUSH_CYC  = 3;
  localparam int DV_W       = N_IN * DOSE_W;
  localparam int PT_W       = DOSE_W + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [DV_W-1:0]   cfg_dose = '0;
  logic              abort = 1'b0;
  logic [N_IN-1:0]   valve_open;
  logic              pump_en;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [PT_W-1:0]   pumped_total;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N_IN-1:0] valve;
    logic            pump;
    logic            counted;
  } step_t;

  step_t trace[$];

  braid_inlet_meter #(
    .N_IN(N_IN), .DOSE_W(DOSE_W), .SETTLE_CYC(SETTLE_CYC), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_dose(cfg_dose), .abort(abort), .valve_open(valve_open), .pump_en(pump_en),
    .busy(busy), .done(done), .aborted(aborted), .pumped_total(pumped_total)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Active-cycle schedule: per nonzero inlet, settle cycles then dose pump cycles.
  function automatic void build_trace(input logic [DV_W-1:0] d);
    step_t s;
    logic [N_IN-1:0] one;
    int dv;
    one = 1;
    trace.delete();
    for (int i = 0; i < N_IN; i++) begin
      dv = int'(d[i*DOSE_W +: DOSE_W]);
      if (dv != 0) begin
        for (int j = 0; j < SETTLE_CYC; j++) begin
          s.valve = one << i; s.pump = 1'b0; s.counted = 1'b0;
          trace.push_back(s);
        end
        for (int j = 0; j < dv; j++) begin
          s.valve = one << i; s.pump = 1'b1; s.counted = 1'b1;
          trace.push_back(s);
        end
      end
    end
`ifdef BRAID_METER_FLUSH_EN
    for (int j = 0; j < FLUSH_CYC; j++) begin
      s.valve = '1; s.pump = 1'b1; s.counted = 1'b0;
      trace.push_back(s);
    end
`endif
  endfunction

  task automatic run_case(input string name, input logic [DV_W-1:0] dose,
                          input int inj_at, input logic [DV_W-1:0] inj_dose,
                          input int abort_sel);
    int abort_at;
    int exp_total;
    build_trace(dose);
    abort_at  = (abort_sel >= 0 && trace.size() > 0) ? (abort_sel % trace.size()) : -1;
    exp_total = 0;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before: cfg_ready=%b expected 1", name, cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_dose  = dose;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int c = 0; c < trace.size(); c++) begin
      checks++;
      if (valve_open !== trace[c].valve || pump_en !== trace[c].pump ||
          busy !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin
        failures++;
        $display("FAIL %s cycle%0d: valve=%b pump=%b busy=%b done=%b aborted=%b expected valve=%b pump=%b busy=1 done=0 aborted=0",
                 name, c, valve_open, pump_en, busy, done, aborted, trace[c].valve, trace[c].pump);
      end
      if (trace[c].counted) exp_total++;
      cfg_valid = (c == inj_at);
      cfg_dose  = (c == inj_at) ? inj_dose : dose;
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cfg_valid = 1'b0;
        checks++;
        if (valve_open !== '0 || pump_en !== 1'b0 || aborted !== 1'b1 || done !== 1'b0 ||
            cfg_ready !== 1'b1 || pumped_total !== PT_W'(exp_total)) begin
          failures++;
          $display("FAIL %s abort@%0d: valve=%b pump=%b aborted=%b done=%b ready=%b total=%0d expected valve=0 pump=0 aborted=1 done=0 ready=1 total=%0d",
                   name, c, valve_open, pump_en, aborted, done, cfg_ready, pumped_total, exp_total);
        end
        @(negedge clk);
        checks++;
        if (aborted !== 1'b0 || pumped_total !== PT_W'(exp_total)) begin
          failures++;
          $display("FAIL %s abort_after: aborted=%b total=%0d expected aborted=0 total=%0d",
                   name, aborted, pumped_total, exp_total);
        end
        return;
      end
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || valve_open !== '0 || pump_en !== 1'b0 || busy !== 1'b1 ||
        aborted !== 1'b0 || pumped_total !== PT_W'(exp_total)) begin
      failures++;
      $display("FAIL %s done_cycle: done=%b valve=%b pump=%b busy=%b aborted=%b total=%0d expected done=1 valve=0 pump=0 busy=1 aborted=0 total=%0d",
               name, done, valve_open, pump_en, busy, aborted, pumped_total, exp_total);
    end
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pumped_total !== PT_W'(exp_total)) begin
      failures++;
      $display("FAIL %s idle_after: ready=%b busy=%b done=%b total=%0d expected ready=1 busy=0 done=0 total=%0d",
               name, cfg_ready, busy, done, pumped_total, exp_total);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (valve_open !== '0 || pump_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        aborted !== 1'b0 || pumped_total !== '0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valve=%b pump=%b busy=%b done=%b aborted=%b total=%0d ready=%b expected all 0, ready=1",
               valve_open, pump_en, busy, done, aborted, pumped_total, cfg_ready);
    end
  endtask

  task automatic test_normal();
    run_case("normal", {8'd1, 8'd2, 8'd0, 8'd3}, -1, '0, -1);
  endtask

  task automatic test_all_zero();
    run_case("all_zero", '0, -1, '0, -1);
  endtask

  task automatic test_abort_dispense();
    // Index SETTLE_CYC+2 is inlet 0's third pump cycle.
    run_case("abort_dispense", {8'd0, 8'd0, 8'd5, 8'd5}, -1, '0, SETTLE_CYC + 2);
  endtask

  task automatic test_cfg_while_busy();
    run_case("cfg_busy", {8'd1, 8'd2, 8'd0, 8'd3}, 4, {4{8'd9}}, -1);
  endtask

  task automatic test_max_dose();
    run_case("max_dose_last_inlet", {8'd255, 8'd0, 8'd0, 8'd0}, -1, '0, -1);
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (aborted !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_idle: aborted=%b busy=%b ready=%b expected 0 0 1", aborted, busy, cfg_ready);
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [DV_W-1:0] d;
    d = {8'd1, 8'd2, 8'd0, 8'd3};
    build_trace(d);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_dose  = d;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (valve_open !== trace[5].valve || pump_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_pre: valve=%b pump=%b expected valve=%b pump=0", valve_open, pump_en, trace[5].valve);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valve_open !== '0 || pump_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: valve=%b pump=%b busy=%b ready=%b done=%b aborted=%b expected valve=0 pump=0 busy=0 ready=1 done=0 aborted=0",
               valve_open, pump_en, busy, cfg_ready, done, aborted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1 || valve_open !== '0 || pumped_total !== '0 || done !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_release: ready=%b valve=%b total=%0d done=%b aborted=%b expected ready=1 valve=0 total=0 done=0 aborted=0",
               cfg_ready, valve_open, pumped_total, done, aborted);
    end
  endtask

  task automatic test_random();
    logic [DV_W-1:0] d;
    logic [DV_W-1:0] junk;
    int inj;
    int ab;
    for (int n = 0; n < 40; n++) begin
      d = '0;
      for (int i = 0; i < N_IN; i++) begin
        if ($urandom_range(0, 2) != 0) d[i*DOSE_W +: DOSE_W] = DOSE_W'($urandom_range(1, 6));
      end
      junk = DV_W'($urandom);
      inj  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1000)) : -1;
      run_case("random", d, inj, junk, ab);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_normal();
    test_all_zero();
    test_abort_dispense();
    test_cfg_while_busy();
    test_max_dose();
    test_abort_idle();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
